// File: rtl/alpha_branch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : alpha_branch                                                     |
// | Brief    : Branch-metric and max-log forward (alpha) recursion, 2-cycle     |
// |            latency. Macro ALPHA_BRANCH_SAT_EN saturates 16-bit outputs.     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module alpha_branch #(
  parameter int BLKLEN_MAX = 6144
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        blklen,
  input  logic               valid_blklen,
  input  logic signed [15:0] sys,
  input  logic signed [15:0] parity,
  input  logic signed [15:0] apriori,
  input  logic               valid_in,
  output logic               in_ready,
  output logic signed [15:0] init_branch1,
  output logic signed [15:0] init_branch2,
  output logic               valid_branch,
  output logic signed [15:0] alpha_0,
  output logic signed [15:0] alpha_1,
  output logic signed [15:0] alpha_2,
  output logic signed [15:0] alpha_3,
  output logic signed [15:0] alpha_4,
  output logic signed [15:0] alpha_5,
  output logic signed [15:0] alpha_6,
  output logic signed [15:0] alpha_7,
  output logic               valid_alpha,
  output logic               done,
  output logic               err
);

  localparam int              c_AW         = 19;
  localparam logic [16:0]     c_LEN_MIN    = 17'd40;
  localparam logic [16:0]     c_LEN_MAX    = 17'(BLKLEN_MAX);
  localparam logic [16:0]     c_TAIL       = 17'd4;
  localparam logic signed [c_AW-1:0] c_A_INIT = -19'sd128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [16:0] r_n;
  logic [16:0] r_in_cnt;
  logic [16:0] r_out_cnt;
  logic        w_load;
  logic        w_reject;
  logic        w_accept;
  logic        w_len_ok;
  logic        w_drain_done;
  logic [16:0] w_len17;

  logic                    r_s1_valid;
  logic signed [c_AW-1:0]  r_g1;
  logic signed [c_AW-1:0]  r_g2;
  logic signed [17:0]      w_sum1;
  logic signed [17:0]      w_sum2;
  logic signed [c_AW-1:0]  w_g1;
  logic signed [c_AW-1:0]  w_g2;

  logic signed [c_AW-1:0]  r_a     [8];
  logic signed [c_AW-1:0]  w_m     [8];
  logic signed [c_AW-1:0]  w_a_nxt [8];
  logic signed [15:0]      r_a_out [8];
  logic signed [15:0]      r_g1_out;
  logic signed [15:0]      r_g2_out;
  logic                    r_vb;
  logic                    r_done;
  logic                    r_err;

  function automatic logic signed [c_AW-1:0] f_max(
    input logic signed [c_AW-1:0] a,
    input logic signed [c_AW-1:0] b
  );
    // Ties keep the first operand.
    return (b > a) ? b : a;
  endfunction

  function automatic logic signed [15:0] f_out16(input logic signed [c_AW-1:0] v);
`ifdef ALPHA_BRANCH_SAT_EN
    if (v > 19'sd32767) begin
      return 16'sh7fff;
    end else if (v < -19'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
`else
    return v[15:0];
`endif
  endfunction

  // ---------------------------------------------------------------- control
  assign w_len17      = {1'b0, blklen};
  assign w_len_ok     = (w_len17 >= c_LEN_MIN) && (w_len17 <= c_LEN_MAX);
  assign w_accept     = valid_in && (r_state == S_RUN);
  assign w_drain_done = (r_state == S_DRAIN) && (r_out_cnt == r_n);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_reject    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (valid_blklen) begin
          if (w_len_ok) begin
            w_load      = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_accept && (r_in_cnt == (r_n - 17'd1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_in_cnt <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_drain_done;
      r_err   <= w_reject;
      if (w_load) begin
        r_n      <= w_len17 + c_TAIL;
        r_in_cnt <= '0;
      end else if (w_accept) begin
        r_in_cnt <= r_in_cnt + 17'd1;
      end
    end
  end

  // ------------------------------------------------- stage 1: branch metrics
  assign w_sum1 = 18'(sys) + 18'(apriori) + 18'(parity);
  assign w_sum2 = 18'(sys) + 18'(apriori) - 18'(parity);
  assign w_g1   = $signed({w_sum1[17], w_sum1}) >>> 1;
  assign w_g2   = $signed({w_sum2[17], w_sum2}) >>> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_g1       <= '0;
      r_g2       <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_g1 <= w_g1;
        r_g2 <= w_g2;
      end
    end
  end

  // ------------------------------------------------ stage 2: alpha recursion
  always_comb begin
    w_m[0] = f_max(r_a[0] - r_g1, r_a[1] + r_g1);
    w_m[1] = f_max(r_a[3] - r_g2, r_a[2] + r_g2);
    w_m[2] = f_max(r_a[4] + r_g2, r_a[5] - r_g2);
    w_m[3] = f_max(r_a[7] + r_g1, r_a[6] - r_g1);
    w_m[4] = f_max(r_a[0] + r_g1, r_a[1] - r_g1);
    w_m[5] = f_max(r_a[3] + r_g2, r_a[2] - r_g2);
    w_m[6] = f_max(r_a[4] - r_g2, r_a[5] + r_g2);
    w_m[7] = f_max(r_a[7] - r_g1, r_a[6] + r_g1);
    for (int i = 0; i < 8; i++) begin
      w_a_nxt[i] = w_m[i] - w_m[0];
    end
  end

  // Outputs show the alphas in force before this symbol's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vb      <= 1'b0;
      r_out_cnt <= '0;
      r_g1_out  <= '0;
      r_g2_out  <= '0;
      r_a[0]    <= '0;
      for (int i = 1; i < 8; i++) begin
        r_a[i] <= c_A_INIT;
      end
      for (int i = 0; i < 8; i++) begin
        r_a_out[i] <= '0;
      end
    end else begin
      r_vb <= r_s1_valid;
      if (w_load) begin
        r_out_cnt <= '0;
        r_a[0]    <= '0;
        for (int i = 1; i < 8; i++) begin
          r_a[i] <= c_A_INIT;
        end
      end else if (r_s1_valid) begin
        r_out_cnt <= r_out_cnt + 17'd1;
        r_g1_out  <= f_out16(r_g1);
        r_g2_out  <= f_out16(r_g2);
        for (int i = 0; i < 8; i++) begin
          r_a_out[i] <= f_out16(r_a[i]);
          r_a[i]     <= w_a_nxt[i];
        end
      end
    end
  end

  assign in_ready     = (r_state == S_RUN);
  assign valid_branch = r_vb;
  assign valid_alpha  = r_vb;
  assign done         = r_done;
  assign err          = r_err;
  assign init_branch1 = r_g1_out;
  assign init_branch2 = r_g2_out;
  assign alpha_0      = r_a_out[0];
  assign alpha_1      = r_a_out[1];
  assign alpha_2      = r_a_out[2];
  assign alpha_3      = r_a_out[3];
  assign alpha_4      = r_a_out[4];
  assign alpha_5      = r_a_out[5];
  assign alpha_6      = r_a_out[6];
  assign alpha_7      = r_a_out[7];

endmodule
`default_nettype wire

// File: tb/tb_alpha_branch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_alpha_branch                                                  |
// | Brief    : Directed self-checking bench for alpha_branch.                   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_alpha_branch;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        blklen;
  logic               valid_blklen;
  logic signed [15:0] sys, parity, apriori;
  logic               valid_in;
  logic               in_ready;
  logic signed [15:0] init_branch1, init_branch2;
  logic               valid_branch, valid_alpha, done, err;
  logic signed [15:0] alpha_0, alpha_1, alpha_2, alpha_3;
  logic signed [15:0] alpha_4, alpha_5, alpha_6, alpha_7;

  int total = 0;
  int bad   = 0;
  int vb_cnt = 0, done_cnt = 0, a0_bad = 0;
  int base_vb, base_done, base_a0, pat_bad;
  logic signed [31:0] exp_g1;

  alpha_branch #(.BLKLEN_MAX(6144)) dut (
    .clk(clk), .rst(rst), .blklen(blklen), .valid_blklen(valid_blklen),
    .sys(sys), .parity(parity), .apriori(apriori), .valid_in(valid_in),
    .in_ready(in_ready), .init_branch1(init_branch1), .init_branch2(init_branch2),
    .valid_branch(valid_branch),
    .alpha_0(alpha_0), .alpha_1(alpha_1), .alpha_2(alpha_2), .alpha_3(alpha_3),
    .alpha_4(alpha_4), .alpha_5(alpha_5), .alpha_6(alpha_6), .alpha_7(alpha_7),
    .valid_alpha(valid_alpha), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_branch === 1'b1) begin
      vb_cnt++;
      if (alpha_0 !== 16'sd0 || valid_alpha !== 1'b1) a0_bad++;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int b);
    for (int k = 0; k < 20 && done_cnt == b; k++) @(posedge clk);
    @(posedge clk);
  endtask

  task automatic load(input logic [15:0] len);
    blklen = len; valid_blklen = 1'b1;
    @(negedge clk);
    valid_blklen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; blklen = '0; valid_blklen = 1'b0; valid_in = 1'b0;
    sys = '0; parity = '0; apriori = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid_branch", valid_branch, 0);
    chk("rst_alpha_1", alpha_1, 0);
    chk("rst_g1", init_branch1, 0);
    chk("rst_done_err", {done, err}, 0);
    rst = 1'b0;

    // rejected block lengths
    load(16'd39);
    chk("err_39", err, 1);
    chk("ready_39", in_ready, 0);
    load(16'd6145);
    chk("err_6145", err, 1);
    chk("ready_6145", in_ready, 0);
    @(negedge clk);
    chk("err_pulse_end", err, 0);

    // all-zero block, continuous input
    base_vb = vb_cnt; base_done = done_cnt; base_a0 = a0_bad;
    load(16'd40);
    chk("run_ready", in_ready, 1);
    for (int i = 0; i < 44; i++) begin
      valid_in = 1'b1;
      @(negedge clk);
      if (i == 0) chk("lat_not_yet", valid_branch, 0);
      if (i == 1) begin
        chk("lat_2", valid_branch, 1);
        chk("zero_g1", init_branch1, 0);
        chk("zero_g2", init_branch2, 0);
        chk("first_a1", alpha_1, -128);
        chk("first_a7", alpha_7, -128);
      end
    end
    valid_in = 1'b0;
    chk("drain_ready", in_ready, 0);
    wait_done(base_done);
    chk("zero_vb_count", vb_cnt - base_vb, 44);
    chk("zero_done_count", done_cnt - base_done, 1);
    chk("zero_a0", a0_bad - base_a0, 0);
    @(negedge clk);

    // toggled input, first symbol 10/2/4 then zeros
    base_vb = vb_cnt; base_done = done_cnt; pat_bad = 0;
    load(16'd40);
    for (int j = 0; j < 88; j++) begin
      valid_in = (j % 2 == 0);
      sys      = (j == 0) ? 16'sd10 : 16'sd0;
      apriori  = (j == 0) ? 16'sd2  : 16'sd0;
      parity   = (j == 0) ? 16'sd4  : 16'sd0;
      @(negedge clk);
      if (valid_branch !== (j % 2 == 1)) pat_bad++;
      if (j == 1) begin
        chk("sym_g1", init_branch1, 8);
        chk("sym_g2", init_branch2, 4);
        chk("sym_a1_init", alpha_1, -128);
        chk("sym_a4_init", alpha_4, -128);
      end
      if (j == 2) chk("hold_g1", init_branch1, 8);
      if (j == 3) begin
        chk("rec1_a1", alpha_1, -116);
        chk("rec1_a3", alpha_3, -112);
        chk("rec1_a4", alpha_4, 16);
        chk("rec1_a7", alpha_7, -112);
        chk("rec1_g1", init_branch1, 0);
      end
      if (j == 5) begin
        chk("rec2_a1", alpha_1, -112);
        chk("rec2_a2", alpha_2, 16);
        chk("rec2_a4", alpha_4, 0);
        chk("rec2_a6", alpha_6, 16);
      end
    end
    valid_in = 1'b0;
    @(negedge clk);
    chk("toggle_done", done, 1);
    chk("toggle_pattern", pat_bad, 0);
    @(posedge clk);
    chk("toggle_vb_count", vb_cnt - base_vb, 44);
    @(negedge clk);

    // reset mid-block, then a fresh block straight after release
    base_done = done_cnt;
    load(16'd40);
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_vb", valid_branch, 0);
    chk("abort_a1", alpha_1, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    base_vb = vb_cnt;
    load(16'd40);
    chk("restart_ready", in_ready, 1);
`ifdef ALPHA_BRANCH_SAT_EN
    exp_g1 = 32767;
`else
    exp_g1 = -16386;
`endif
    for (int i = 0; i < 44; i++) begin
      valid_in = 1'b1;
      sys     = (i == 0) ? 16'sd32767 : 16'sd0;
      apriori = (i == 0) ? 16'sd32767 : 16'sd0;
      parity  = (i == 0) ? 16'sd32767 : 16'sd0;
      @(negedge clk);
      if (i == 1) begin
        chk("big_g1", init_branch1, exp_g1);
        chk("big_g2", init_branch2, 16383);
      end
    end
    valid_in = 1'b0;
    wait_done(base_done);
    chk("restart_vb_count", vb_cnt - base_vb, 44);
    chk("restart_done_count", done_cnt - base_done, 1);
    chk("all_a0_zero", a0_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alpha_branch.md
ALPHA_BRANCH -- requirements
Module: alpha_branch

Interface
REQ-001 SHALL have parameter BLKLEN_MAX, default 6144: largest accepted block length.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port blklen, input, 16: block length K, without tail.
REQ-005 SHALL have port valid_blklen, input, 1: blklen strobe; starts a block.
REQ-006 SHALL have ports sys, parity and apriori, input, 16 each: signed symbol LLRs.
REQ-007 SHALL have port valid_in, input, 1: symbol strobe covering sys, parity and apriori.
REQ-008 SHALL have port in_ready, output, 1: high while a symbol can be accepted.
REQ-009 SHALL have ports init_branch1 and init_branch2, output, 16 each: signed branch metrics g1 and g2.
REQ-010 SHALL have port valid_branch, output, 1: branch-metric and alpha strobe.
REQ-011 SHALL have ports alpha_0 .. alpha_7, output, 16 each: signed normalised forward metrics.
REQ-012 SHALL have port valid_alpha, output, 1: identical to valid_branch.
REQ-013 SHALL have port done, output, 1: one-cycle pulse after the last symbol is output.
REQ-014 SHALL have port err, output, 1: one-cycle pulse when blklen is rejected.

Function
REQ-015 SHALL implement the state machine IDLE -> RUN -> DRAIN -> IDLE.
REQ-016 IDLE: on valid_blklen with 40 <= blklen <= BLKLEN_MAX, SHALL latch N = blklen+4 and go to RUN; otherwise SHALL pulse err and stay in IDLE.
REQ-017 SHALL ignore valid_blklen outside IDLE.
REQ-018 in_ready SHALL be 1 only in RUN; valid_in while in_ready=0 SHALL be ignored.
REQ-019 RUN SHALL accept one symbol per cycle with valid_in high and no gaps required, and SHALL count accepted symbols.
REQ-020 When the N-th symbol is accepted, SHALL go to DRAIN.
REQ-021 DRAIN SHALL last until the last output is issued, then SHALL pulse done for one cycle and return to IDLE.
REQ-022 Branch metrics SHALL be g1 = (sys+apriori+parity)>>>1 and g2 = (sys+apriori-parity)>>>1, using 18-bit signed intermediates and an arithmetic shift.
REQ-023 Alpha SHALL be initialised at block start to a0=0 and a1..a7=-128.
REQ-024 The 19-bit signed max-log recursion SHALL be: a0'=max(a0-g1, a1+g1); a1'=max(a3-g2, a2+g2); a2'=max(a4+g2, a5-g2); a3'=max(a7+g1, a6-g1); a4'=max(a0+g1, a1-g1); a5'=max(a3+g2, a2-g2); a6'=max(a4-g2, a5+g2); a7'=max(a7-g1, a6+g1).
REQ-025 Ties in the max SHALL select the first operand.
REQ-026 Normalisation SHALL subtract a0' from all eight new metrics, so stored a0 is always 0.
REQ-027 For symbol k, the outputs SHALL carry g1_k, g2_k and the alphas before the update with symbol k, i.e. alpha_k; the first output therefore shows 0/-128.
REQ-028 Latency SHALL be exactly 2 cycles: valid_in accepted at cycle t gives valid_branch=1 at t+2.
REQ-029 Gaps in valid_in SHALL produce matching gaps in valid_branch.
REQ-030 Exactly N valid_branch pulses SHALL be produced per block.
REQ-031 Outputs SHALL hold their last value when valid_branch=0.

Reset
REQ-032 rst SHALL force state IDLE, counters 0, in_ready/valid_branch/valid_alpha/done/err 0, branch and alpha outputs 0, and internal alphas to their initial values.
REQ-033 rst mid-block SHALL abort the block without a done pulse; the first cycle after rst is released SHALL accept valid_blklen.

Configuration
REQ-034 SHALL support macro ALPHA_BRANCH_SAT_EN.
REQ-035 With ALPHA_BRANCH_SAT_EN defined, the 16-bit outputs (g1, g2, alphas) SHALL saturate to [-32768, 32767].
REQ-036 Without ALPHA_BRANCH_SAT_EN, outputs SHALL be the low 16 bits, two's-complement wrap.
REQ-037 Internal 19-bit recursion SHALL be unaffected by ALPHA_BRANCH_SAT_EN.

Verification
REQ-038 blklen=40, then 44 symbols all zero -> 44 valid_branch pulses starting 2 cycles after the first valid_in; g1=g2=0; alpha_0=0 throughout; first output alpha_1..7=-128; done pulses once.
REQ-039 Single symbol sys=10, apriori=2, parity=4 -> g1=8, g2=4; the next output's alphas are the recursion from 0/-128 with a0 normalised to 0.
REQ-040 blklen=39 and blklen=6145 -> err pulse, state remains IDLE, in_ready=0.
REQ-041 valid_in toggled 1/0 every cycle -> valid_branch mirrors the pattern delayed by 2 cycles; count is still N.
REQ-042 rst asserted after 20 symbols -> all outputs 0, no done; a new blklen=40 block then completes normally.
REQ-043 sys=apriori=parity=32767 -> g1 = 32767 with ALPHA_BRANCH_SAT_EN, and the wrapped low 16 bits of 49150 without it.
